// File: rtl/iso_state_loader.sv
// Byte-serial loader that maps a 128-bit AES state into the isomorphic field
// through a single shared 8x8 GF(2) matrix multiplier.

package iso_pkg;
   // Row r of the matrix produces output bit r: out[r] = parity(row_r & in).
   typedef logic [7:0][7:0] mm_matrix_t;
endpackage

module input_transform
   import iso_pkg::*;
(
   input  logic [7:0]  din,
   input  mm_matrix_t  mat,
   output logic [7:0]  dout
);
   always_comb begin
      dout = '0;
      for (int r = 0; r < 8; r++) begin
         dout[r] = ^(mat[r] & din);
      end
   end
endmodule

module iso_state_loader
   import iso_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_state,
   input  mm_matrix_t   L,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_state,
   output logic         busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] XFORM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]   state;
   logic [3:0]   cnt;
   logic [0:127] src_p0;
   mm_matrix_t   mat_p0;
   logic [0:127] obuf_p1;
   logic [7:0]   src_byte;
   logic [7:0]   xf_byte;

   assign src_byte = src_p0[{cnt, 3'b000} +: 8];

   input_transform u_xf (
      .din  (src_byte),
      .mat  (mat_p0),
      .dout (xf_byte)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         src_p0  <= '0;
         mat_p0  <= '0;
         obuf_p1 <= '0;
      end else begin
         case (state)
            // capture stage: block and matrix are frozen until the next accept
            IDLE: begin
               if (in_valid) begin
                  src_p0 <= in_state;
                  mat_p0 <= L;
                  cnt    <= 4'd0;
                  state  <= XFORM;
               end
            end
            // transform stage: one byte per cycle into the output buffer
            XFORM: begin
               obuf_p1[{cnt, 3'b000} +: 8] <= xf_byte;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_state = obuf_p1;

endmodule

// File: tb/tb_iso_state_loader.sv
// Scoreboard bench for iso_state_loader: expected blocks are queued at accept
// and compared when the converted block appears.

module tb_iso_state_loader;
   import iso_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] in_state;
   mm_matrix_t   L;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] out_state;
   logic         busy;

   int total = 0;
   int bad   = 0;
   logic [0:127] sb[$];

   iso_state_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .L         (L),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: XOR together the matrix columns selected by the input bits.
   function automatic logic [7:0] ref_byte(mm_matrix_t m, logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] col;
      acc = 8'h00;
      for (int j = 0; j < 8; j++) begin
         for (int r = 0; r < 8; r++) col[r] = m[r][j];
         if (b[j]) acc = acc ^ col;
      end
      return acc;
   endfunction

   function automatic logic [0:127] ref_state(mm_matrix_t m, logic [0:127] s);
      logic [0:127] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = ref_byte(m, s[8*k +: 8]);
      return o;
   endfunction

   function automatic mm_matrix_t ident();
      mm_matrix_t m;
      for (int r = 0; r < 8; r++) m[r] = 8'h01 << r;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [0:127] s, input mm_matrix_t m);
      in_state = s;
      L        = m;
      in_valid = 1'b1;
      sb.push_back(ref_state(m, s));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_state = '0; L = '0;
      tick(); tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      logic [0:127] s, exp;
      int lat;
      s = 128'h00112233445566778899AABBCCDDEEFF;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL id_in_ready got=%b want=1", in_ready); end
      accept(s, ident());
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL id_busy_xform got=%b want=1", busy); end
      wait_valid(lat);
      total++; if (lat !== 16) begin bad++; $display("FAIL id_latency got=%0d want=16", lat); end
      exp = sb.pop_front();
      total++; if (out_state !== s) begin bad++; $display("FAIL id_out_state got=%h want=%h", out_state, s); end
      total++; if (out_state !== exp) begin bad++; $display("FAIL id_scoreboard got=%h want=%h", out_state, exp); end
      total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL id_done_flags got=busy%b/rdy%b want=busy1/rdy0", busy, in_ready); end
      drain();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL id_back_idle got=v%b/b%b/r%b want=v0/b0/r1", out_valid, busy, in_ready); end
   endtask

   task automatic test_zero_parity();
      logic [0:127] s, exp;
      mm_matrix_t m;
      int lat;
      s = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      accept(s, '0);
      wait_valid(lat);
      exp = sb.pop_front();
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL zero_out_state got=%h want=0", out_state); end
      total++; if (out_state !== exp) begin bad++; $display("FAIL zero_scoreboard got=%h want=%h", out_state, exp); end
      drain();
      for (int r = 0; r < 8; r++) m[r] = 8'hFF;
      s = {4{32'h010307_80}};
      accept(s, m);
      wait_valid(lat);
      exp = sb.pop_front();
      total++; if (out_state !== {4{32'hFF00FFFF}}) begin bad++; $display("FAIL parity_out_state got=%h want=%h", out_state, {4{32'hFF00FFFF}}); end
      total++; if (out_state !== exp) begin bad++; $display("FAIL parity_scoreboard got=%h want=%h", out_state, exp); end
      drain();
   endtask

   task automatic test_capture();
      logic [0:127] s, exp;
      int lat;
      s = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
      accept(s, ident());
      repeat (5) tick();
      L = '0;
      in_state = ~s;
      wait_valid(lat);
      exp = sb.pop_front();
      total++; if (out_state !== s) begin bad++; $display("FAIL capture_out_state got=%h want=%h", out_state, s); end
      total++; if (lat !== 11) begin bad++; $display("FAIL capture_latency got=%0d want=11", lat); end
      total++; if (out_state !== exp) begin bad++; $display("FAIL capture_scoreboard got=%h want=%h", out_state, exp); end
      drain();
   endtask

   task automatic test_backpressure();
      logic [0:127] a, b, exp;
      mm_matrix_t ma, mb;
      int lat;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      ma = {$urandom, $urandom};
      mb = {$urandom, $urandom};
      accept(a, ma);
      wait_valid(lat);
      exp = sb.pop_front();
      total++; if (out_state !== exp) begin bad++; $display("FAIL bp_first got=%h want=%h", out_state, exp); end
      in_state = b; L = mb; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         total++; if (out_state !== exp || out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_hold cyc=%0d got=%h/v%b want=%h/v1", i, out_state, out_valid, exp); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b want=0", i, in_ready); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got=v%b/r%b/b%b want=v0/r1/b0", out_valid, in_ready, busy); end
      sb.push_back(ref_state(mb, b));
      tick();
      in_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept got=%b want=1", busy); end
      wait_valid(lat);
      total++; if (lat !== 16) begin bad++; $display("FAIL bp_second_latency got=%0d want=16", lat); end
      exp = sb.pop_front();
      total++; if (out_state !== exp) begin bad++; $display("FAIL bp_second got=%h want=%h", out_state, exp); end
      drain();
   endtask

   task automatic test_mid_reset();
      logic [0:127] s, exp;
      int lat;
      s = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      accept(~s, ident());
      repeat (7) tick();
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      void'(sb.pop_front());
      total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_idle got=b%b/r%b want=b0/r1", busy, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL rst_out_state got=%h want=0", out_state); end
      accept(s, ident());
      wait_valid(lat);
      exp = sb.pop_front();
      total++; if (lat !== 16) begin bad++; $display("FAIL rst_next_latency got=%0d want=16", lat); end
      total++; if (out_state !== s || out_state !== exp) begin bad++; $display("FAIL rst_next_state got=%h want=%h", out_state, s); end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [0:127] exp;
      int cyc, nacc, nout, last_acc;
      cyc = 0; nacc = 0; nout = 0; last_acc = 0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      L = {$urandom, $urandom};
      in_valid = 1'b1; out_ready = 1'b1;
      while (nout < 4 && cyc < 200) begin
         if (out_valid === 1'b1) begin
            exp = sb.pop_front();
            total++; if (out_state !== exp) begin bad++; $display("FAIL b2b_out%0d got=%h want=%h", nout, out_state, exp); end
            nout++;
         end
         if (in_ready === 1'b1 && in_valid === 1'b1) begin
            sb.push_back(ref_state(L, in_state));
            if (nacc > 0) begin
               total++; if (cyc - last_acc !== 18) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=18", nacc, cyc - last_acc); end
            end
            last_acc = cyc;
            nacc++;
            tick(); cyc++;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            L = {$urandom, $urandom};
            if (nacc == 4) in_valid = 1'b0;
         end else begin
            tick(); cyc++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++; if (nout !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nout); end
      tick();
   endtask

   initial begin
      test_reset();
      test_identity();
      test_zero_parity();
      test_capture();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
